if_fetch_queue: RTL and testbench
=================================

# if_fetch_queue

Instruction-fetch front end that sits directly upstream of the instruction decode stage. Owns the program counter, issues word reads to a one-cycle-latency synchronous instruction memory, and buffers returned instructions with their PCs in a small show-ahead queue. The decode stage consumes entries under a valid/stall handshake. A redirect input from the jump/branch logic flushes the queue and any in-flight read.

## Interface
- DEPTH, 4: queue entries; a power of two, 2..16.
- RESET_PC, 32'h0000_0000: first fetch address after reset; word-aligned.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  read request this cycle.
- imem_addr  out  32  read address; valid when imem_req=1.
- imem_rdata  in  32  instruction word, valid the cycle after the request.
- id_valid  out  1  queue head holds a valid instruction.
- id_instr  out  32  head instruction; 32'h0000_0000 (NOP) when id_valid=0.
- id_pc  out  32  PC of the head instruction; 0 when id_valid=0.
- id_stall  in  1  decode cannot accept this cycle; the head is held.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored and forced to 0.

## Operation
- State: fetch_pc (32 b), inflight flag plus inflight_pc, queue storage of DEPTH×64 b, read/write pointers, and count (clog2(DEPTH)+1 b).
- Issue: imem_req = rst_n && !redirect && (count + inflight − pop) < DEPTH. pop = id_valid && !id_stall. imem_addr = fetch_pc. On issue:
  - fetch_pc <= fetch_pc + 4, wrapping 32'hFFFF_FFFC → 0.
  - inflight <= 1 and inflight_pc <= fetch_pc.
- If no request is issued, inflight <= 0.
- Return: when inflight=1 and the cycle has no redirect, push {imem_rdata, inflight_pc} at the write pointer.
- Credit accounting guarantees a free slot for every push, so overflow cannot occur. The bench asserts count ≤ DEPTH.
- Pop: when pop=1, advance the read pointer. The head is shown combinationally from queue storage.
- Push and pop in the same cycle: both occur and count is unchanged. This is legal when full, because issue was gated on the pop.
- Empty: id_valid=0, id_instr=0, id_pc=0. A pop with id_valid=0 is a no-op.
- Redirect has priority over push, pop and issue in its cycle:
  - count <= 0 and pointers <= 0.
  - inflight <= 0, so the response arriving this cycle is discarded.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No imem_req in the redirect cycle.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (async assert; deassert synchronous to clk):
  - fetch_pc=RESET_PC, inflight=0, count=0, pointers=0.
  - imem_req=0 while rst_n=0.
  - id_valid=0, id_instr=0, id_pc=0.
- Cycle 0, the first edge with rst_n=1: imem_req=1 with imem_addr=RESET_PC.
- Fetch latency: request in cycle N, rdata in cycle N+1 and written at the end of N+1, id_valid=1 in cycle N+2.
- Steady state with id_stall=0: one instruction per cycle, no bubbles.
- Redirect in cycle R:
  - Request to redirect_pc in R+1.
  - First new instruction at the head in R+3.
  - Queue empty (id_valid=0) in R+1 and R+2.
- Redirect in the cycle after a request drops that response.
- Redirect while full: same behaviour as any other redirect.
- Redirect together with id_stall: redirect wins.
- Reset mid-operation clears everything immediately, including the inflight flag. Stale rdata after deassert is ignored.
- id_stall held: the head entry is stable on id_instr and id_pc every cycle. Fetch continues until count + inflight reaches DEPTH, then imem_req=0.

## Test plan
- Reset, memory model returns instr = addr | 32'hA000_0000, id_stall=0 -> imem_addr 0,4,8,… each cycle. First id_valid in cycle 2 with id_pc=0, id_instr=32'hA000_0000, then one per cycle with no gaps.
- id_stall=1 from cycle 2 for 10 cycles -> exactly DEPTH+0 entries accepted, imem_req falls to 0, head stays id_pc=0. After release, the PCs 0,4,…,16 drain in order with none lost or duplicated.
- Redirect to 32'h0000_0103 in cycle 6 -> no request in 6, imem_addr=32'h100 in 7. The response to the cycle-5 request is discarded. id_valid=0 in 7–8 and id_pc=32'h100 in 9.
- Redirect while full with id_stall=1 -> count goes to 0 next cycle. id_valid=0 until the new stream arrives, and no old PC ever appears.
- redirect_pc=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004 (wrap).
- rst_n pulsed low for half a cycle mid-stream with the queue half full -> outputs go to 0 asynchronously. Restart at RESET_PC with no stale entries.

Source files
------------

// File: rtl/if_fetch_queue_if.sv
// Bundle of fetch-side memory port and decode-side handshake for if_fetch_queue.
// master = fetch unit, slave = memory/decode environment.
interface if_fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc,
    input  imem_rdata, id_stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc,
    output imem_rdata, id_stall, redirect, redirect_pc
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the PC, reads a 1-cycle synchronous imem and
// buffers {instr, pc} in a show-ahead queue drained by decode; redirect flushes.
module if_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  if_fetch_queue_if.master  fq
);

  localparam int unsigned   PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_W = DEPTH[CW:0];

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   mem_q [DEPTH];

  logic          valid_s;
  logic          pop_s;
  logic          push_s;
  logic          issue_s;
  logic [CW:0]   occ_s;
  logic [63:0]   head_s;

  assign valid_s = (count_q != '0);
  assign pop_s   = valid_s && !fq.id_stall;
  assign push_s  = inflight_q && !fq.redirect;

  // Credits: a request may only go out if its response is guaranteed a slot,
  // counting the slot a same-cycle pop frees.
  assign occ_s   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop_s};
  assign issue_s = rst_n && !fq.redirect && (occ_s < DEPTH_W);

  assign head_s       = mem_q[rd_ptr_q];
  assign fq.imem_req  = issue_s;
  assign fq.imem_addr = fetch_pc_q;
  assign fq.id_valid  = valid_s;
  assign fq.id_instr  = valid_s ? head_s[63:32] : 32'h0000_0000;
  assign fq.id_pc     = valid_s ? head_s[31:0]  : 32'h0000_0000;

  // Next-state logic; redirect overrides issue, push and pop in its cycle.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (fq.redirect) begin
      fetch_pc_d = fq.redirect_pc & 32'hFFFF_FFFC;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue_s) begin
        fetch_pc_d    = fetch_pc_q + 32'd4;
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
      end else begin
        inflight_d    = 1'b0;
      end
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0000_0000;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Queue storage; contents are only observable through count, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {fq.imem_rdata, inflight_pc_q};
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a 1-cycle memory returning addr | 32'hA000_0000.
module tb_if_fetch_queue;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  if_fetch_queue_if bus ();

  if_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fq    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= bus.imem_addr | 32'hA000_0000;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 unit into cycle 0 minus the settle delay each test adds.
  task automatic do_reset(input logic [31:0] rpc, input logic rdir);
    rst_n           = 1'b0;
    bus.id_stall    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0000_0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.redirect    = rdir;
    bus.redirect_pc = rpc;
    rst_n           = 1'b1;
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus.id_stall    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0000_0000;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (bus.imem_req !== 1'b0 || bus.id_valid !== 1'b0 || bus.id_instr !== 32'h0 || bus.id_pc !== 32'h0) begin
      n_err++;
      $display("FAIL reset_hold got req=%b v=%b instr=%h pc=%h want all 0",
               bus.imem_req, bus.id_valid, bus.id_instr, bus.id_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_cycle0 got req=%b addr=%h v=%b want req=1 addr=0 v=0",
               bus.imem_req, bus.imem_addr, bus.id_valid);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset(32'h0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      #1;
      n_vec++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * c)) begin
        n_err++;
        $display("FAIL stream_req c=%0d got req=%b addr=%h want req=1 addr=%h",
                 c, bus.imem_req, bus.imem_addr, 32'(4 * c));
      end
      exp_pc = (c >= 2) ? 32'(4 * (c - 2)) : 32'h0;
      n_vec++;
      if (bus.id_valid !== (c >= 2) || bus.id_pc !== exp_pc ||
          bus.id_instr !== ((c >= 2) ? (exp_pc | 32'hA000_0000) : 32'h0)) begin
        n_err++;
        $display("FAIL stream_head c=%0d got v=%b pc=%h instr=%h want v=%b pc=%h",
                 c, bus.id_valid, bus.id_pc, bus.id_instr, (c >= 2), exp_pc);
      end
    end
  endtask

  task automatic test_stall();
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    do_reset(32'h0, 1'b0);
    for (int c = 0; c < 18; c++) begin
      if (c > 0) tick();
      bus.id_stall = (c >= 2 && c < 12);
      #1;
      exp_req  = (c <= 3) || (c >= 12);
      exp_addr = (c <= 3) ? 32'(4 * c) : 32'(16 + 4 * (c - 12));
      n_vec++;
      if (bus.imem_req !== exp_req || (exp_req && bus.imem_addr !== exp_addr)) begin
        n_err++;
        $display("FAIL stall_req c=%0d got req=%b addr=%h want req=%b addr=%h",
                 c, bus.imem_req, bus.imem_addr, exp_req, exp_addr);
      end
      exp_pc = (c >= 12) ? 32'(4 * (c - 12)) : 32'h0;
      n_vec++;
      if (bus.id_valid !== (c >= 2) || bus.id_pc !== exp_pc ||
          bus.id_instr !== ((c >= 2) ? (exp_pc | 32'hA000_0000) : 32'h0)) begin
        n_err++;
        $display("FAIL stall_head c=%0d got v=%b pc=%h instr=%h want v=%b pc=%h",
                 c, bus.id_valid, bus.id_pc, bus.id_instr, (c >= 2), exp_pc);
      end
    end
    bus.id_stall = 1'b0;
  endtask

  task automatic test_redirect();
    logic        exp_req;
    logic        exp_v;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    do_reset(32'h0, 1'b0);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) tick();
      bus.redirect    = (c == 6);
      bus.redirect_pc = (c == 6) ? 32'h0000_0103 : 32'h0;
      #1;
      exp_req  = (c != 6);
      exp_addr = (c < 6) ? 32'(4 * c) : 32'(32'h100 + 4 * (c - 7));
      n_vec++;
      if (bus.imem_req !== exp_req || (exp_req && bus.imem_addr !== exp_addr)) begin
        n_err++;
        $display("FAIL redir_req c=%0d got req=%b addr=%h want req=%b addr=%h",
                 c, bus.imem_req, bus.imem_addr, exp_req, exp_addr);
      end
      exp_v  = (c >= 2 && c <= 6) || (c >= 9);
      exp_pc = (c >= 9) ? 32'(32'h100 + 4 * (c - 9)) : ((c >= 2 && c <= 6) ? 32'(4 * (c - 2)) : 32'h0);
      n_vec++;
      if (bus.id_valid !== exp_v || bus.id_pc !== exp_pc ||
          bus.id_instr !== (exp_v ? (exp_pc | 32'hA000_0000) : 32'h0)) begin
        n_err++;
        $display("FAIL redir_head c=%0d got v=%b pc=%h instr=%h want v=%b pc=%h",
                 c, bus.id_valid, bus.id_pc, bus.id_instr, exp_v, exp_pc);
      end
    end
    bus.redirect = 1'b0;
  endtask

  task automatic test_redirect_full();
    logic        exp_req;
    logic        exp_v;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    do_reset(32'h0, 1'b0);
    for (int c = 0; c < 15; c++) begin
      if (c > 0) tick();
      bus.id_stall    = (c >= 2 && c < 12);
      bus.redirect    = (c == 7);
      bus.redirect_pc = (c == 7) ? 32'h0000_0200 : 32'h0;
      #1;
      exp_req  = (c <= 3) || (c >= 8);
      exp_addr = (c <= 3) ? 32'(4 * c) : 32'(32'h200 + 4 * (c - 8));
      n_vec++;
      if (bus.imem_req !== exp_req || (exp_req && bus.imem_addr !== exp_addr)) begin
        n_err++;
        $display("FAIL full_redir_req c=%0d got req=%b addr=%h want req=%b addr=%h",
                 c, bus.imem_req, bus.imem_addr, exp_req, exp_addr);
      end
      exp_v  = (c >= 2 && c <= 7) || (c >= 10);
      exp_pc = (c >= 13) ? 32'(32'h200 + 4 * (c - 12)) : ((c >= 10) ? 32'h200 : 32'h0);
      n_vec++;
      if (bus.id_valid !== exp_v || bus.id_pc !== exp_pc ||
          bus.id_instr !== (exp_v ? (exp_pc | 32'hA000_0000) : 32'h0)) begin
        n_err++;
        $display("FAIL full_redir_head c=%0d got v=%b pc=%h instr=%h want v=%b pc=%h",
                 c, bus.id_valid, bus.id_pc, bus.id_instr, exp_v, exp_pc);
      end
    end
    bus.id_stall = 1'b0;
    bus.redirect = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    do_reset(32'hFFFF_FFF8, 1'b1);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) tick();
      bus.redirect = (c == 0);
      #1;
      exp_addr = 32'hFFFF_FFF8 + 32'(4 * (c - 1));
      n_vec++;
      if (bus.imem_req !== (c != 0) || (c != 0 && bus.imem_addr !== exp_addr)) begin
        n_err++;
        $display("FAIL wrap_req c=%0d got req=%b addr=%h want req=%b addr=%h",
                 c, bus.imem_req, bus.imem_addr, (c != 0), exp_addr);
      end
      exp_pc = (c >= 3) ? (32'hFFFF_FFF8 + 32'(4 * (c - 3))) : 32'h0;
      n_vec++;
      if (bus.id_valid !== (c >= 3) || bus.id_pc !== exp_pc ||
          bus.id_instr !== ((c >= 3) ? (exp_pc | 32'hA000_0000) : 32'h0)) begin
        n_err++;
        $display("FAIL wrap_head c=%0d got v=%b pc=%h instr=%h want v=%b pc=%h",
                 c, bus.id_valid, bus.id_pc, bus.id_instr, (c >= 3), exp_pc);
      end
    end
    bus.redirect = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [31:0] exp_pc;
    do_reset(32'h0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      bus.id_stall = (c >= 2);
      #1;
      n_vec++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * c)) begin
        n_err++;
        $display("FAIL areset_pre_req c=%0d got req=%b addr=%h want req=1 addr=%h",
                 c, bus.imem_req, bus.imem_addr, 32'(4 * c));
      end
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.imem_req !== 1'b0 || bus.id_valid !== 1'b0 || bus.id_instr !== 32'h0 || bus.id_pc !== 32'h0) begin
      n_err++;
      $display("FAIL areset_async got req=%b v=%b instr=%h pc=%h want all 0",
               bus.imem_req, bus.id_valid, bus.id_instr, bus.id_pc);
    end
    #4;
    rst_n        = 1'b1;
    bus.id_stall = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      #1;
      n_vec++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * c)) begin
        n_err++;
        $display("FAIL areset_req c=%0d got req=%b addr=%h want req=1 addr=%h",
                 c, bus.imem_req, bus.imem_addr, 32'(4 * c));
      end
      exp_pc = (c >= 2) ? 32'(4 * (c - 2)) : 32'h0;
      n_vec++;
      if (bus.id_valid !== (c >= 2) || bus.id_pc !== exp_pc ||
          bus.id_instr !== ((c >= 2) ? (exp_pc | 32'hA000_0000) : 32'h0)) begin
        n_err++;
        $display("FAIL areset_head c=%0d got v=%b pc=%h instr=%h want v=%b pc=%h",
                 c, bus.id_valid, bus.id_pc, bus.id_instr, (c >= 2), exp_pc);
      end
    end
  endtask

  initial begin
    bus.id_stall    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0000_0000;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_full();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
